// File: rtl/pps_pkg.sv
// Shared types and widths for the PPS conditioner: FSM state codes, counter width
// and a saturating increment used by the edge-to-edge period counter.
package pps_pkg;

    localparam int STATE_W = 4;
    localparam int CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        ACQUIRE  = 4'd1,
        LOCKED   = 4'd2,
        HOLDOVER = 4'd3
    } pps_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pps_if.sv
// Bundle between the PPS pin, the conditioner and its consumers (burst generator SYNC
// input plus status/debug); master is the conditioner side.
interface pps_if;
    import pps_pkg::*;

    logic               i_pps_raw;
    logic               o_sync;
    logic               o_locked;
    logic               o_holdover;
    logic [CNT_W-1:0]   o_period;
    logic [7:0]         o_miss_cnt;
    logic [STATE_W-1:0] o_cstate;

    modport master (
        input  i_pps_raw,
        output o_sync, o_locked, o_holdover, o_period, o_miss_cnt, o_cstate
    );

    modport slave (
        output i_pps_raw,
        input  o_sync, o_locked, o_holdover, o_period, o_miss_cnt, o_cstate
    );

endinterface

// File: rtl/pps_glitch_filter.sv
// Two-flop synchroniser, persistence filter on the level and a one-cycle strobe on
// each filtered rising edge.
module pps_glitch_filter #(
    parameter int FILT_LEN = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic pps_raw,
    output logic rise
);

    localparam int FCW = $clog2(FILT_LEN + 1);

    logic [1:0]     sync_reg;
    logic [FCW-1:0] cnt_reg;
    logic           level_reg;
    logic           rise_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], pps_raw};
            rise_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == FCW'(FILT_LEN - 1)) begin
                // The level only moves after FILT_LEN consecutive disagreeing samples.
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
                rise_reg  <= ~level_reg;
            end else begin
                cnt_reg <= cnt_reg + FCW'(1);
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/pps_conditioner.sv
// Turns the raw PPS pin into a validated one-cycle SYNC strobe, tracks lock and
// bridges short outages with a bounded number of synthetic strobes.
module pps_conditioner
    import pps_pkg::*;
#(
    parameter int NOMINAL_PERIOD = 100_000_000,
    parameter int PERIOD_TOL     = 1000,
    parameter int FILT_LEN       = 16,
    parameter int LOCK_CNT       = 3,
    parameter int HOLD_MAX       = 10
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    pps_if.master bus
);

    localparam logic [CNT_W-1:0] PMIN      = CNT_W'(NOMINAL_PERIOD - PERIOD_TOL);
    localparam logic [CNT_W-1:0] PMAX      = CNT_W'(NOMINAL_PERIOD + PERIOD_TOL);
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(NOMINAL_PERIOD + PERIOD_TOL + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(NOMINAL_PERIOD - 1);
    localparam int               GOOD_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    logic              pps_edge;
    logic [CNT_W-1:0]  since_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  hold_reg, hold_next;
    pps_state_t        state_reg, state_next;
    logic [GOOD_W-1:0] good_reg, good_next;
    logic [7:0]        miss_reg, miss_next;
    logic              sync_reg, sync_next;
    logic              valid;
    logic              timeout;
    logic              hold_wrap;

    pps_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .pps_raw (bus.i_pps_raw),
        .rise    (pps_edge)
    );

    assign valid     = (since_reg >= PMIN) && (since_reg <= PMAX);
    assign timeout   = (since_reg == TMO);
    assign hold_wrap = (hold_reg == HOLD_LAST);

    // since_reg restarts at 1 so that it reads the true spacing at the next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            since_reg  <= '0;
            period_reg <= '0;
        end else if (pps_edge) begin
            period_reg <= since_reg;
            since_reg  <= CNT_W'(1);
        end else begin
            since_reg  <= sat_inc(since_reg);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            good_reg  <= '0;
            miss_reg  <= '0;
            hold_reg  <= '0;
            sync_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            good_reg  <= good_next;
            miss_reg  <= miss_next;
            hold_reg  <= hold_next;
            sync_reg  <= sync_next;
        end
    end

    // A real edge is tested first in every state so it always beats timeout/wrap.
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        miss_next  = miss_reg;
        sync_next  = 1'b0;
        hold_next  = '0;
        if (state_reg == HOLDOVER) begin
            hold_next = hold_wrap ? '0 : hold_reg + CNT_W'(1);
        end
        case (state_reg)
            IDLE: begin
                if (pps_edge) begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                end
            end
            ACQUIRE: begin
                if (pps_edge) begin
                    if (!valid) begin
                        good_next = '0;
                    end else if (good_reg == GOOD_W'(LOCK_CNT - 1)) begin
                        state_next = LOCKED;
                        good_next  = '0;
                        sync_next  = 1'b1;
                    end else begin
                        good_next = good_reg + GOOD_W'(1);
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            LOCKED: begin
                if (pps_edge) begin
                    if (valid) begin
                        sync_next = 1'b1;
                    end else begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end
                end else if (timeout) begin
                    state_next = HOLDOVER;
                    sync_next  = 1'b1;
                    miss_next  = 8'd1;
                end
            end
            HOLDOVER: begin
                if (pps_edge) begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                    miss_next  = '0;
                end else if (hold_wrap) begin
                    if (miss_reg == 8'(HOLD_MAX)) begin
                        state_next = IDLE;
                        miss_next  = '0;
                    end else begin
                        sync_next = 1'b1;
                        miss_next = miss_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                good_next  = '0;
                miss_next  = '0;
            end
        endcase
        sync_next = sync_next & ~sync_reg;
    end

    assign bus.o_sync     = sync_reg;
    assign bus.o_locked   = (state_reg == LOCKED);
    assign bus.o_holdover = (state_reg == HOLDOVER);
    assign bus.o_period   = period_reg;
    assign bus.o_miss_cnt = miss_reg;
    assign bus.o_cstate   = state_reg;

endmodule
